// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold / shift right / shift left / parallel load.
// Latency: 1 clock from the sampling edge of ctrl/d to q; q is driven straight from flops.
// Backpressure: none; a new operation is accepted on every rising clk edge.
// Optional: define UNIV_SHIFT_REG_SOUT_EN to add the registered serial-out ports so_r / so_l.

module univ_shift_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] d,
`ifdef UNIV_SHIFT_REG_SOUT_EN
    output logic         so_r,
    output logic         so_l,
`endif
    output logic [N-1:0] q
);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_SHR   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic [N-1:0] r_q;
    logic [N-1:0] r_d;

    // Next-state select; shifts fill from the matching end of d so repeated
    // shifts saturate to the fill bit rather than wrapping around.
    always_comb begin
        r_d = r_q;
        case (ctrl)
            OP_HOLD: r_d = r_q;
            OP_SHR:  r_d = {d[N-1], r_q[N-1:1]};
            OP_SHL:  r_d = {r_q[N-2:0], d[0]};
            OP_LOAD: r_d = d;
            default: r_d = r_q;
        endcase
    end

    // Main register; reset clears it immediately and keeps it clear while low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign q = r_q;

`ifdef UNIV_SHIFT_REG_SOUT_EN
    logic so_r_q;
    logic so_r_d;
    logic so_l_q;
    logic so_l_d;

    // Capture the bit that falls off each end; each holds on every other op.
    always_comb begin
        so_r_d = so_r_q;
        so_l_d = so_l_q;
        if (ctrl == OP_SHR) begin
            so_r_d = r_q[0];
        end
        if (ctrl == OP_SHL) begin
            so_l_d = r_q[N-1];
        end
    end

    // Serial-out flops share the register's reset so both clear together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            so_r_q <= 1'b0;
            so_l_q <= 1'b0;
        end else begin
            so_r_q <= so_r_d;
            so_l_q <= so_l_d;
        end
    end

    assign so_r = so_r_q;
    assign so_l = so_l_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (N=4): directed vectors with hand-computed results.
// Stimulus pushes the expected post-edge state; a monitor pops and compares after each edge.
// Asynchronous reset behaviour is checked inline at the instants it must take effect.

module tb_univ_shift_reg;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [1:0]   ctrl;
    logic [N-1:0] d;
    logic [N-1:0] q;
`ifdef UNIV_SHIFT_REG_SOUT_EN
    logic         so_r;
    logic         so_l;
`endif

    typedef struct packed {
        logic [N-1:0] q;
        logic         so_r;
        logic         so_l;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int vectors    = 0;
    int miscompares = 0;

    univ_shift_reg #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl),
        .d    (d),
`ifdef UNIV_SHIFT_REG_SOUT_EN
        .so_r (so_r),
        .so_l (so_l),
`endif
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_q(input string nm, input logic [N-1:0] exp_v);
        vectors++;
        if (q !== exp_v) begin
            miscompares++;
            $display("FAIL %s: q=%h expected %h at %0t", nm, q, exp_v, $time);
        end
    endtask

    task automatic check_so(input string nm, input logic er, input logic el);
`ifdef UNIV_SHIFT_REG_SOUT_EN
        vectors++;
        if (so_r !== er || so_l !== el) begin
            miscompares++;
            $display("FAIL %s: so_r/so_l=%b%b expected %b%b at %0t", nm, so_r, so_l, er, el, $time);
        end
`else
        if (er === 1'bx && el === 1'bx) begin
            $display("note %s: serial outs not built", nm);
        end
`endif
    endtask

    // Monitor: every rising edge presents a new state; compare if one is expected.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check_q(nm, e.q);
            check_so(nm, e.so_r, e.so_l);
        end
    end

    // Drive one operation between edges and queue the state expected after the next edge.
    task automatic step(input logic [1:0] c, input logic [N-1:0] dv,
                        input logic [N-1:0] eq, input logic er, input logic el,
                        input string nm);
        @(negedge clk);
        ctrl = c;
        d    = dv;
        exp_q.push_back('{q: eq, so_r: er, so_l: el});
        name_q.push_back(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, queue=%0d expected 0", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b0;
        ctrl = 2'b11;
        d    = 4'hF;

        // Reset held low across an edge with load selected: q stays 0.
        for (int t = 0; t < 5; t++) begin
            #2;
            check_q("rst_hold", 4'h0);
        end
        check_so("rst_hold_so", 1'b0, 1'b0);

        // Release between edges; first edge performs the selected load.
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back('{q: 4'hF, so_r: 1'b0, so_l: 1'b0});
        name_q.push_back("rst_release_load");

        // Load and hold.
        step(2'b11, 4'h6, 4'h6, 1'b0, 1'b0, "load6");
        step(2'b00, 4'h6, 4'h6, 1'b0, 1'b0, "hold1");
        step(2'b00, 4'h6, 4'h6, 1'b0, 1'b0, "hold2");

        // Inputs changed between edges but restored before the edge: no effect.
        step(2'b00, 4'h6, 4'h6, 1'b0, 1'b0, "glitch_hold");
        #1; ctrl = 2'b11; d = 4'h5;
        #1; ctrl = 2'b00; d = 4'h6;

        // Right shift, MSB fill 0.
        step(2'b01, 4'h6, 4'h3, 1'b0, 1'b0, "shr1");
        step(2'b01, 4'h6, 4'h1, 1'b1, 1'b0, "shr2");
        step(2'b01, 4'h6, 4'h0, 1'b1, 1'b0, "shr3");
        step(2'b01, 4'h6, 4'h0, 1'b0, 1'b0, "shr4");
        step(2'b01, 4'h6, 4'h0, 1'b0, 1'b0, "shr5");

        // Left shift, LSB fill 0.
        step(2'b11, 4'h6, 4'h6, 1'b0, 1'b0, "reload6_a");
        step(2'b10, 4'h6, 4'hC, 1'b0, 1'b0, "shl1");
        step(2'b10, 4'h6, 4'h8, 1'b0, 1'b1, "shl2");
        step(2'b10, 4'h6, 4'h0, 1'b0, 1'b1, "shl3");
        step(2'b10, 4'h6, 4'h0, 1'b0, 1'b0, "shl4");
        step(2'b10, 4'h6, 4'h0, 1'b0, 1'b0, "shl5");

        // Left shift, LSB fill 1.
        step(2'b11, 4'h6, 4'h6, 1'b0, 1'b0, "reload6_b");
        step(2'b10, 4'h9, 4'hD, 1'b0, 1'b0, "shl_f1");
        step(2'b10, 4'h9, 4'hB, 1'b0, 1'b1, "shl_f2");
        step(2'b10, 4'h9, 4'h7, 1'b0, 1'b1, "shl_f3");
        step(2'b10, 4'h9, 4'hF, 1'b0, 1'b0, "shl_f4");
        step(2'b10, 4'h9, 4'hF, 1'b0, 1'b1, "shl_f5");

        // Reset pulsed mid shift sequence, between edges.
        step(2'b11, 4'h6, 4'h6, 1'b0, 1'b1, "reload6_c");
        step(2'b01, 4'h6, 4'h3, 1'b0, 1'b1, "shr_pre_rst");
        @(negedge clk);
        #1; rst = 1'b0;
        #1; check_q("mid_rst_async", 4'h0);
        check_so("mid_rst_async_so", 1'b0, 1'b0);
        #1; ctrl = 2'b00; rst = 1'b1;
        #1; check_q("mid_rst_released", 4'h0);
        exp_q.push_back('{q: 4'h0, so_r: 1'b0, so_l: 1'b0});
        name_q.push_back("post_rst_hold1");
        step(2'b00, 4'h6, 4'h0, 1'b0, 1'b0, "post_rst_hold2");

        // Drain: every queued expectation must have been consumed.
        @(posedge clk);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
